iob_cache_write_buffer: RTL and testbench
=========================================

Name: iob_cache_write_buffer

Overview:
Write-through buffer that sits directly upstream of the cache back-end write channel. It queues front-end write requests (word address, data, byte strobes) in a small FIFO and drains them one at a time into the back-end write channel's valid/ready port. It decouples front-end stores from back-end latency. It also reports occupancy so the cache controller can stall reads until the buffer is empty.

Parameters:
ADDR_W, 22, word address width (FE_ADDR_W - FE_NBYTES_W)
DATA_W, 32, front-end data width; strobe width is DATA_W/8
DEPTH_W, 2, log2 of entry count (default 4 entries); legal range 1..4

Ports:
clk_i  in  1  clock
cke_i  in  1  clock enable; low freezes all state
rst_n_i  in  1  reset, synchronous, active-low
wr_valid_i  in  1  front-end write request
wr_addr_i  in  ADDR_W  word address
wr_wdata_i  in  DATA_W  write data
wr_wstrb_i  in  DATA_W/8  byte strobes
wr_ready_o  out  1  entry accepted this cycle if wr_valid_i high
write_valid_o  out  1  head entry valid toward back-end write channel
write_addr_o  out  ADDR_W  head address
write_wdata_o  out  DATA_W  head data
write_wstrb_o  out  DATA_W/8  head strobes
write_ready_i  in  1  back-end write channel consumed head this cycle
empty_o  out  1  no entries held
full_o  out  1  2**DEPTH_W entries held
level_o  out  DEPTH_W+1  current entry count

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is synchronous and active-low.
- Reset (rst_n_i low at a clk_i edge):
  - Takes effect regardless of cke_i.
  - rd_ptr, wr_ptr and level are cleared to 0.
  - Entry storage is not cleared.
- Outputs after reset: level_o=0, empty_o=1, full_o=0, write_valid_o=0, write_addr_o/wdata_o/wstrb_o=0, wr_ready_o=1.
- While rst_n_i is low, wr_ready_o is forced to 0.
- Storage: register array of 2**DEPTH_W entries, each {addr, wdata, wstrb}. Pointers are DEPTH_W bits and wrap modulo 2**DEPTH_W. level is DEPTH_W+1 bits.
- Push:
  - Occurs when wr_valid_i & wr_ready_o & cke_i.
  - Writes the entry at wr_ptr, then wr_ptr+1.
  - wr_ready_o = !full_o. A push is never accepted when full, even if a pop happens in the same cycle.
- Pop:
  - Occurs when write_valid_o & write_ready_i & cke_i, then rd_ptr+1.
  - write_ready_i while write_valid_o is low is ignored.
- Head outputs:
  - write_valid_o = !empty_o.
  - write_addr_o/wdata_o/wstrb_o show the entry at rd_ptr, masked to 0 when empty.
  - Head fields stay stable while write_valid_o is high and write_ready_i is low.
- Latency: no bypass. An entry pushed into an empty buffer appears on write_valid_o the next cycle.
- Level update:
  - Push only: level+1.
  - Pop only: level-1.
  - Push and pop in the same cycle (only possible when 0<level<max): level unchanged, both pointers advance.
  - empty_o = (level==0); full_o = (level==2**DEPTH_W). Both are combinational from the level register.
- Ordering: strict FIFO. Entries are never merged or reordered.
- cke_i low: pointers, level and storage hold; push and pop are both suppressed; outputs reflect the held state.
- Reset during a pending drain: the pending entry is discarded, and write_valid_o is 0 on the cycle after the reset edge.

Test Plan:
- Reset then 4 back-to-back pushes (addr 0x10..0x13, wdata 0xA0..0xA3, wstrb 0xF), write_ready_i=0:
  - level_o goes 1,2,3,4; full_o=1; wr_ready_o=0.
  - A 5th push of 0x14 is not accepted; level stays 4.
- From full, pulse write_ready_i on 4 consecutive cycles:
  - Back-end sees addr 0x10,0x11,0x12,0x13 in order.
  - empty_o=1 after the 4th pop; write_valid_o=0; write outputs=0.
- Level 2, push 0x20 and pop in the same cycle:
  - level_o stays 2; head advances to the next entry; 0x20 is later drained last.
- Full, push and pop in the same cycle:
  - Pop taken, push rejected; level_o=3; the rejected entry must be re-presented by the source.
- Hold write_ready_i=0 for 10 cycles with level 1:
  - write_valid_o stays 1; addr/wdata/wstrb stay constant every cycle.
- cke_i=0 with wr_valid_i=1 and write_ready_i=1 for 3 cycles:
  - No level change.
- Then rst_n_i=0 for 1 cycle at level 3:
  - Next cycle level_o=0, write_valid_o=0.
  - wr_ready_o=0 during reset and 1 after.

Source files
------------

// File: rtl/iob_cache_write_buffer.sv
// iob_cache_write_buffer: FIFO write-through buffer feeding the cache back-end write channel
module iob_cache_write_buffer #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 2
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_n_i,
  input  logic                wr_valid_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_wdata_i,
  input  logic [DATA_W/8-1:0] wr_wstrb_i,
  output logic                wr_ready_o,
  output logic                write_valid_o,
  output logic [ADDR_W-1:0]   write_addr_o,
  output logic [DATA_W-1:0]   write_wdata_o,
  output logic [DATA_W/8-1:0] write_wstrb_o,
  input  logic                write_ready_i,
  output logic                empty_o,
  output logic                full_o,
  output logic [DEPTH_W:0]    level_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int ENT_W  = ADDR_W + DATA_W + STRB_W;
  localparam int DEPTH  = 2 ** DEPTH_W;
  localparam logic [DEPTH_W:0] MAX_LVL = {1'b1, {DEPTH_W{1'b0}}};
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [ENT_W-1:0]   mem_d [DEPTH];
  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W:0]   level_q, level_d;
  logic               push, pop;
  logic [ENT_W-1:0]   head;
  assign empty_o       = level_q == '0;
  assign full_o        = level_q == MAX_LVL;
  assign level_o       = level_q;
  assign wr_ready_o    = rst_n_i & ~full_o;
  assign write_valid_o = ~empty_o;
  assign push          = wr_valid_i & wr_ready_o & cke_i;
  assign pop           = write_valid_o & write_ready_i & cke_i;
  // Head is masked when empty so the back-end never sees stale storage
  assign head          = empty_o ? '0 : mem_q[rd_ptr_q];
  assign {write_addr_o, write_wdata_o, write_wstrb_o} = head;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {wr_addr_i, wr_wdata_i, wr_wstrb_i};
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = (push && !pop) ? level_q + 1'b1 : (pop && !push) ? level_q - 1'b1 : level_q;
  end
  always_ff @(posedge clk_i) mem_q <= mem_d;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: tb/tb_iob_cache_write_buffer.sv
// tb_iob_cache_write_buffer: directed and randomized checks against a queue-based FIFO model
module tb_iob_cache_write_buffer;
  localparam int ADDR_W = 22, DATA_W = 32, DEPTH_W = 2, DEPTH = 4;
  typedef struct packed {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; logic [3:0] s;} ent_t;
  logic clk = 0, cke = 1, rst_n = 0, wr_valid = 0, write_ready = 0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_wdata = '0;
  logic [3:0] wr_wstrb = '0;
  logic wr_ready, write_valid, empty, full;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_wdata;
  logic [3:0] write_wstrb;
  logic [DEPTH_W:0] level;
  int n_tests = 0, n_fail = 0;
  ent_t mq[$];

  iob_cache_write_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W)) dut (
    .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr),
    .wr_wdata_i(wr_wdata), .wr_wstrb_i(wr_wstrb), .wr_ready_o(wr_ready),
    .write_valid_o(write_valid), .write_addr_o(write_addr), .write_wdata_o(write_wdata),
    .write_wstrb_o(write_wstrb), .write_ready_i(write_ready), .empty_o(empty), .full_o(full),
    .level_o(level));

  always #5 clk = ~clk;

  task automatic cycle();
    bit pu, po;
    ent_t e;
    pu = rst_n && cke && wr_valid && (mq.size() < DEPTH);
    po = rst_n && cke && write_ready && (mq.size() > 0);
    e = '{wr_addr, wr_wdata, wr_wstrb};
    @(posedge clk);
    if (!rst_n) mq.delete();
    else begin
      if (po) mq.delete(0);
      if (pu) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic push_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_valid = 1; wr_addr = a; wr_wdata = d; wr_wstrb = 4'hF; write_ready = 0;
    cycle();
    wr_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; wr_valid = 0; write_ready = 0; cke = 1;
    #1;
    n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low: got %0b want 0", wr_ready); end
    cycle();
    rst_n = 1;
    #1;
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", level); end
    n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got empty=%0b full=%0b want 1/0", empty, full); end
    n_tests++; if (write_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", write_valid); end
    n_tests++; if ({write_addr, write_wdata, write_wstrb} !== '0) begin n_fail++; $display("FAIL rst_head: got %0h/%0h/%0h want 0", write_addr, write_wdata, write_wstrb); end
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", wr_ready); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      push_one(ADDR_W'(32'h10 + i), 32'hA0 + i);
      n_tests++; if (level !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_level%0d: got %0d want %0d", i, level, i + 1); end
    end
    n_tests++; if (full !== 1'b1 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got full=%0b ready=%0b want 1/0", full, wr_ready); end
    push_one(22'h14, 32'hA4);
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_reject: got %0d want 4", level); end
  endtask

  task automatic test_drain();
    wr_valid = 0; write_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (write_valid !== 1'b1 || write_addr !== ADDR_W'(32'h10 + i) || write_wdata !== 32'hA0 + i || write_wstrb !== 4'hF) begin
        n_fail++; $display("FAIL drain_head%0d: got v=%0b a=%0h d=%0h want 1 %0h %0h", i, write_valid, write_addr, write_wdata, 32'h10 + i, 32'hA0 + i); end
      cycle();
    end
    write_ready = 0;
    n_tests++; if (empty !== 1'b1 || write_valid !== 1'b0 || {write_addr, write_wdata, write_wstrb} !== '0) begin
      n_fail++; $display("FAIL drain_empty: got empty=%0b v=%0b a=%0h d=%0h", empty, write_valid, write_addr, write_wdata); end
  endtask

  task automatic test_back_to_back();
    push_one(22'h30, 32'h300);
    push_one(22'h31, 32'h301);
    wr_valid = 1; wr_addr = 22'h20; wr_wdata = 32'h200; write_ready = 1;
    cycle();
    wr_valid = 0; write_ready = 0;
    n_tests++; if (level !== 3'd2 || write_addr !== 22'h31) begin n_fail++; $display("FAIL b2b_level_head: got %0d/%0h want 2/31", level, write_addr); end
    write_ready = 1; cycle();
    n_tests++; if (write_addr !== 22'h20 || write_wdata !== 32'h200) begin n_fail++; $display("FAIL b2b_last: got %0h/%0h want 20/200", write_addr, write_wdata); end
    cycle(); write_ready = 0;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %0b want 1", empty); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) push_one(ADDR_W'(32'h40 + i), 32'h400 + i);
    wr_valid = 1; wr_addr = 22'h50; wr_wdata = 32'h500; write_ready = 1;
    cycle();
    wr_valid = 0;
    n_tests++; if (level !== 3'd3 || write_addr !== 22'h41) begin n_fail++; $display("FAIL fullpp: got level=%0d head=%0h want 3/41", level, write_addr); end
    for (int i = 1; i < 4; i++) begin
      n_tests++; if (write_addr !== ADDR_W'(32'h40 + i)) begin n_fail++; $display("FAIL fullpp_order%0d: got %0h want %0h", i, write_addr, 32'h40 + i); end
      cycle();
    end
    write_ready = 0;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fullpp_empty: got %0b want 1 (rejected entry stored)", empty); end
  endtask

  task automatic test_hold();
    logic [DATA_W-1:0] d;
    d = $urandom;
    wr_valid = 1; wr_addr = 22'h60; wr_wdata = d; wr_wstrb = 4'h5; write_ready = 0;
    cycle();
    wr_valid = 0;
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (write_valid !== 1'b1 || write_addr !== 22'h60 || write_wdata !== d || write_wstrb !== 4'h5) begin
        n_fail++; $display("FAIL hold%0d: got v=%0b a=%0h d=%0h s=%0h want 1 60 %0h 5", i, write_valid, write_addr, write_wdata, write_wstrb, d); end
      cycle();
    end
    write_ready = 1; cycle(); write_ready = 0;
  endtask

  task automatic test_cke_reset();
    for (int i = 0; i < 3; i++) push_one(ADDR_W'(32'h70 + i), 32'h700 + i);
    cke = 0; wr_valid = 1; wr_addr = 22'h7F; write_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++; if (level !== 3'd3 || write_addr !== 22'h70) begin n_fail++; $display("FAIL cke%0d: got level=%0d head=%0h want 3/70", i, level, write_addr); end
    end
    cke = 1; wr_valid = 0; write_ready = 0; rst_n = 0;
    #1;
    n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst3_ready_low: got %0b want 0", wr_ready); end
    cycle();
    rst_n = 1;
    #1;
    n_tests++; if (level !== 3'd0 || write_valid !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst3_after: got level=%0d v=%0b ready=%0b want 0/0/1", level, write_valid, wr_ready); end
  endtask

  task automatic test_random();
    ent_t h;
    for (int i = 0; i < 400; i++) begin
      cke = $urandom_range(0, 7) != 0;
      rst_n = $urandom_range(0, 59) != 0;
      wr_valid = $urandom_range(0, 1);
      write_ready = $urandom_range(0, 2) != 0;
      wr_addr = ADDR_W'($urandom); wr_wdata = $urandom; wr_wstrb = 4'($urandom);
      #1;
      h = mq.size() > 0 ? mq[0] : '0;
      n_tests++; if (level !== 3'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
        n_fail++; $display("FAIL rand_level%0d: got %0d e=%0b f=%0b want %0d", i, level, empty, full, mq.size()); end
      n_tests++; if (write_valid !== (mq.size() > 0) || {write_addr, write_wdata, write_wstrb} !== h) begin
        n_fail++; $display("FAIL rand_head%0d: got v=%0b %0h/%0h/%0h want %0h/%0h/%0h", i, write_valid, write_addr, write_wdata, write_wstrb, h.a, h.d, h.s); end
      n_tests++; if (wr_ready !== (rst_n && mq.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_ready%0d: got %0b want %0b", i, wr_ready, rst_n && mq.size() < DEPTH); end
      cycle();
    end
    cke = 1; rst_n = 1; wr_valid = 0; write_ready = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_push_pop();
    test_hold();
    test_cke_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
